// File: rtl/board_redraw_scheduler.sv
// Minesweeper board redraw scheduler: walks all 64 tiles of an 8x8 board,
// emitting one 19x14 pixel block per tile to a VGA adapter, using a snapshot
// of the board maps taken at the start of each frame.
module board_redraw_scheduler (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [63:0] mine_map,
    input  logic [63:0] flag_map,
    input  logic [63:0] step_map,
    input  logic        reveal_all,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  color,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PX_W      = 5;
    localparam int unsigned PY_W      = 4;
    localparam int unsigned TILE_W    = 6;
    localparam int unsigned PX_LAST   = 18;
    localparam int unsigned PY_LAST   = 13;
    localparam int unsigned TILE_LAST = 63;
    localparam int unsigned PITCH_X   = 20;
    localparam int unsigned PITCH_Y   = 15;

    localparam logic [2:0] COL_RED   = 3'b100;
    localparam logic [2:0] COL_WHITE = 3'b111;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_BLUE  = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                pending;
    logic                clr_pending;
    logic [PX_W-1:0]     px;
    logic [PY_W-1:0]     py;
    logic [TILE_W-1:0]   tile;
    logic [63:0]         snap_mine;
    logic [63:0]         snap_flag;
    logic [63:0]         snap_step;
    logic                snap_reveal;
    logic                px_wrap;
    logic                py_wrap;
    logic                last_pixel;

    assign px_wrap    = (px == PX_W'(PX_LAST));
    assign py_wrap    = (py == PY_W'(PY_LAST));
    assign last_pixel = px_wrap && py_wrap && (tile == TILE_W'(TILE_LAST));

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode
    always_comb begin
        state_nxt   = state;
        plot        = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        clr_pending = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
                busy      = 1'b1;
                state_nxt = DRAW;
            end
            DRAW: begin
                busy = 1'b1;
                plot = 1'b1;
                if (last_pixel) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // A request arriving in this very cycle still triggers a rerun
                if (pending || start) begin
                    state_nxt   = LATCH;
                    clr_pending = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Coalesce requests made while a frame is in flight into one rerun
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= 1'b0;
        end else if (clr_pending) begin
            pending <= 1'b0;
        end else if (start && (state != IDLE)) begin
            pending <= 1'b1;
        end
    end

    // Board snapshot, taken once per frame
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snap_mine   <= '0;
            snap_flag   <= '0;
            snap_step   <= '0;
            snap_reveal <= 1'b0;
        end else if (state == LATCH) begin
            snap_mine   <= mine_map;
            snap_flag   <= flag_map;
            snap_step   <= step_map;
            snap_reveal <= reveal_all;
        end
    end

    // Pixel and tile counters: px fastest, then py, then tile
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            px   <= '0;
            py   <= '0;
            tile <= '0;
        end else if (state == LATCH) begin
            px   <= '0;
            py   <= '0;
            tile <= '0;
        end else if (state == DRAW) begin
            if (px_wrap) begin
                px <= '0;
                if (py_wrap) begin
                    py   <= '0;
                    tile <= tile + TILE_W'(1);
                end else begin
                    py <= py + PY_W'(1);
                end
            end else begin
                px <= px + PX_W'(1);
            end
        end
    end

    // Pixel coordinates from tile position and in-tile offset
    always_comb begin
        x = 8'(tile[2:0]) * 8'(PITCH_X) + 8'(px);
        y = 7'(tile[5:3]) * 7'(PITCH_Y) + 7'(py);
    end

    // Tile colour, highest priority first
    always_comb begin
        color = COL_BLUE;
        if (snap_step[tile] && snap_mine[tile]) begin
            color = COL_RED;
        end else if (snap_step[tile]) begin
            color = COL_WHITE;
        end else if (snap_flag[tile]) begin
            color = COL_GREEN;
        end else if (snap_reveal && snap_mine[tile]) begin
            color = COL_RED;
        end
    end

endmodule

// File: tb/tb_board_redraw_scheduler.sv
// Scoreboard bench for board_redraw_scheduler: stimulus pushes the expected
// pixel stream of each frame; a monitor pops and compares on every plot/done.
module tb_board_redraw_scheduler;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [63:0] mine_map;
    logic [63:0] flag_map;
    logic [63:0] step_map;
    logic        reveal_all;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  color;
    logic        plot;
    logic        busy;
    logic        done;

    board_redraw_scheduler dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .mine_map   (mine_map),
        .flag_map   (flag_map),
        .step_map   (step_map),
        .reveal_all (reveal_all),
        .x          (x),
        .y          (y),
        .color      (color),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int px;
        int py;
        int c;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference colour of a tile from the board rules
    function automatic int ref_color(input bit mine, input bit flag, input bit step, input bit rev);
        if (step && mine) return 4;
        if (step)         return 7;
        if (flag)         return 2;
        if (rev && mine)  return 4;
        return 1;
    endfunction

    // Expected frame: every tile in order, each a 19x14 block, then a done
    task automatic push_frame(input logic [63:0] m, input logic [63:0] f,
                              input logic [63:0] s, input logic r);
        exp_t e;
        for (int t = 0; t < 64; t++) begin
            for (int yy = 0; yy < 14; yy++) begin
                for (int xx = 0; xx < 19; xx++) begin
                    e.is_done = 1'b0;
                    e.px = (t % 8) * 20 + xx;
                    e.py = (t / 8) * 15 + yy;
                    e.c  = ref_color(m[t], f[t], s[t], r);
                    exp_q.push_back(e);
                end
            end
        end
        e.is_done = 1'b1;
        e.px = 0;
        e.py = 0;
        e.c  = 0;
        exp_q.push_back(e);
    endtask

    // Monitor: every plot and done must match the head of the scoreboard
    always @(negedge clk) begin
        if (resetn) begin
            if (plot) begin
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_plot: got plot at (%0d,%0d), required no plot (t=%0t)",
                             x, y, $time);
                end else begin
                    check("pix_x", int'(x), exp_q[0].px);
                    check("pix_y", int'(y), exp_q[0].py);
                    check("pix_color", int'(color), exp_q[0].c);
                    void'(exp_q.pop_front());
                end
            end
            if (done) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 with %0d pixels outstanding, required done=0 (t=%0t)",
                             exp_q.size(), $time);
                end else begin
                    n_tests++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Pulse start for one sampling edge; afterwards we are in the LATCH cycle
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycles until done is seen; returns -1 on timeout
    task automatic wait_done(input string name, output int k);
        k = -1;
        for (int c = 1; c <= 20000; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                k = c;
                break;
            end
        end
        if (k < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done within 20000 cycles, required done", name);
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            check({name, "_busy"}, int'(busy), 0);
            check({name, "_plot"}, int'(plot), 0);
        end
    endtask

    initial begin
        int k;
        logic [63:0] m;
        logic [63:0] f;
        logic [63:0] f2;
        logic [63:0] s;
        logic        r;

        resetn     = 1'b0;
        start      = 1'b0;
        mine_map   = '0;
        flag_map   = '0;
        step_map   = '0;
        reveal_all = 1'b0;

        // Reset state
        #12;
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_color", int'(color), 1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check_idle("post_reset", 3);

        // Empty board: all blue, done 17025 edges after the start edge
        push_frame('0, '0, '0, 1'b0);
        pulse_start();
        check("empty_latch_busy", int'(busy), 1);
        check("empty_latch_plot", int'(plot), 0);
        wait_done("empty", k);
        check("empty_done_latency", k, 17025);
        @(posedge clk);
        #1;
        check("empty_done_width", int'(done), 0);
        check("empty_back_idle", int'(busy), 0);

        // Flag on tile 9 plus colour priority cases on tiles 0, 5 and 63
        mine_map   = (64'd1 << 63) | (64'd1 << 5);
        step_map   = (64'd1 << 63) | 64'd1;
        flag_map   = (64'd1 << 9) | 64'd1;
        reveal_all = 1'b1;
        push_frame(mine_map, flag_map, step_map, reveal_all);
        pulse_start();
        check("prio_latch_busy", int'(busy), 1);
        wait_done("prio", k);
        check("prio_done_latency", k, 17025);
        check_idle("prio_idle", 3);

        // Reset mid-frame aborts without a done pulse
        m = {$urandom(), $urandom()};
        f = {$urandom(), $urandom()};
        s = {$urandom(), $urandom()};
        r = 1'($urandom_range(1));
        mine_map = m; flag_map = f; step_map = s; reveal_all = r;
        push_frame(m, f, s, r);
        pulse_start();
        repeat (600) @(posedge clk);
        #3;
        check("abort_plot_before", int'(plot), 1);
        resetn = 1'b0;
        #1;
        check("abort_plot", int'(plot), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_color", int'(color), 1);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("abort_idle_busy", int'(busy), 0);
            check("abort_idle_plot", int'(plot), 0);
            check("abort_idle_done", int'(done), 0);
        end

        // Snapshot and coalesced pending: flags change mid-frame, two requests
        m  = {$urandom(), $urandom()};
        f  = {$urandom(), $urandom()};
        s  = {$urandom(), $urandom()};
        r  = 1'($urandom_range(1));
        f2 = f ^ ({$urandom(), $urandom()} | 64'd1);
        mine_map = m; flag_map = f; step_map = s; reveal_all = r;
        push_frame(m, f, s, r);
        pulse_start();
        repeat (3000) @(posedge clk);
        #1;
        flag_map = f2;
        push_frame(m, f2, s, r);
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        pulse_start();
        wait_done("pend_first", k);
        @(posedge clk);
        #1;
        check("pend_rerun_busy", int'(busy), 1);
        check("pend_rerun_plot", int'(plot), 0);
        check("pend_rerun_done", int'(done), 0);
        wait_done("pend_second", k);
        check("pend_second_latency", k, 17025);
        check_idle("pend_single_rerun", 20);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
